rom_port_arbiter: RTL and testbench

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Shared single-port ROM arbiter: buffers download writes, round-robins CPU/graphics
// reads, and holds the game core in reset through and shortly after a download.
module rom_port_arbiter #(
    parameter int unsigned ROM_SIZE      = 131072,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_download,
    input  logic        dl_wr,
    input  logic [16:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        cpu_req,
    input  logic [14:0] cpu_addr,
    output logic        cpu_ack,
    output logic [7:0]  cpu_data,
    input  logic        gfx_req,
    input  logic [15:0] gfx_addr,
    output logic        gfx_ack,
    output logic [7:0]  gfx_data,
    output logic [16:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic        game_reset,
    output logic        dl_overflow
);

    localparam int unsigned CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WRITE
    } state_t;

    state_t        state_q, state_d;
    logic          wr_pend_q, wr_pend_d;
    logic [16:0]   hold_addr_q, hold_addr_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          grant_gfx_q, grant_gfx_d;
    logic          last_gfx_q, last_gfx_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          gfx_ack_q, gfx_ack_d;
    logic [7:0]    cpu_data_q, cpu_data_d;
    logic [7:0]    gfx_data_q, gfx_data_d;
    logic          ovf_q, ovf_d;
    logic          dl_prev_q;
    logic [CW-1:0] settle_q, settle_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_pend_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            grant_gfx_q <= 1'b0;
            last_gfx_q  <= 1'b1;
            cpu_ack_q   <= 1'b0;
            gfx_ack_q   <= 1'b0;
            cpu_data_q  <= '0;
            gfx_data_q  <= '0;
            ovf_q       <= 1'b0;
            dl_prev_q   <= 1'b0;
            settle_q    <= CW'(SETTLE_CYCLES);
        end else begin
            state_q     <= state_d;
            wr_pend_q   <= wr_pend_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            grant_gfx_q <= grant_gfx_d;
            last_gfx_q  <= last_gfx_d;
            cpu_ack_q   <= cpu_ack_d;
            gfx_ack_q   <= gfx_ack_d;
            cpu_data_q  <= cpu_data_d;
            gfx_data_q  <= gfx_data_d;
            ovf_q       <= ovf_d;
            dl_prev_q   <= dl_download;
            settle_q    <= settle_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_pend_d   = wr_pend_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        grant_gfx_d = grant_gfx_q;
        last_gfx_d  = last_gfx_q;
        cpu_ack_d   = 1'b0;
        gfx_ack_d   = 1'b0;
        cpu_data_d  = cpu_data_q;
        gfx_data_d  = gfx_data_q;
        ovf_d       = ovf_q;
        settle_d    = settle_q;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_din     = '0;

        if (dl_download && !dl_prev_q) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // The ack cycle is a turnaround: requesters still hold req while they see ack.
                if (wr_pend_q) begin
                    state_d = WRITE;
                end else if (!dl_download && !cpu_ack_q && !gfx_ack_q && (cpu_req || gfx_req)) begin
                    state_d     = RD_ADDR;
                    grant_gfx_d = gfx_req && (!cpu_req || !last_gfx_q);
                end
            end
            RD_ADDR: begin
                mem_addr = grant_gfx_q ? {1'b1, gfx_addr} : {2'b00, cpu_addr};
                state_d  = RD_DATA;
            end
            RD_DATA: begin
                if (grant_gfx_q) begin
                    gfx_data_d = mem_dout;
                    gfx_ack_d  = 1'b1;
                end else begin
                    cpu_data_d = mem_dout;
                    cpu_ack_d  = 1'b1;
                end
                last_gfx_d = grant_gfx_q;
                state_d    = IDLE;
            end
            WRITE: begin
                wr_pend_d = 1'b0;
                if ({15'd0, hold_addr_q} < ROM_SIZE) begin
                    mem_we   = 1'b1;
                    mem_addr = hold_addr_q;
                    mem_din  = hold_data_q;
                end else begin
                    ovf_d = 1'b1;
                end
                state_d = IDLE;
            end
        endcase

        if (dl_wr) begin
            hold_addr_d = dl_addr;
            hold_data_d = dl_data;
            wr_pend_d   = 1'b1;
        end

        if (dl_download || wr_pend_q) begin
            settle_d = CW'(SETTLE_CYCLES);
        end else if (settle_q != '0) begin
            settle_d = settle_q - CW'(1);
        end

        game_reset = dl_download || wr_pend_q || (settle_q != '0);
    end

    assign cpu_ack     = cpu_ack_q;
    assign gfx_ack     = gfx_ack_q;
    assign cpu_data    = cpu_data_q;
    assign gfx_data    = gfx_data_q;
    assign dl_overflow = ovf_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter with a synchronous ROM model;
// a second instance with a 64 KiB ROM exercises the overflow path.
module tb_rom_port_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_download, dl_wr;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic        cpu_req, gfx_req;
    logic [14:0] cpu_addr;
    logic [15:0] gfx_addr;
    logic        cpu_ack, gfx_ack, mem_we, game_reset, dl_overflow;
    logic [7:0]  cpu_data, gfx_data, mem_din;
    logic [7:0]  mem_dout = 8'h00;
    logic [16:0] mem_addr;

    logic        cpu_ack2, gfx_ack2, mem_we2, game_reset2, dl_overflow2;
    logic [7:0]  cpu_data2, gfx_data2, mem_din2;
    logic [16:0] mem_addr2;

    logic [7:0]  mem [0:131071];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cpu_acks = 0;
    int          gfx_acks = 0;
    int          acks_before;

    always #5 clk_sys = ~clk_sys;

    rom_port_arbiter u_dut (
        .clk_sys(clk_sys), .reset(reset),
        .dl_download(dl_download), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
        .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_ack(gfx_ack), .gfx_data(gfx_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
        .game_reset(game_reset), .dl_overflow(dl_overflow)
    );

    rom_port_arbiter #(.ROM_SIZE(65536), .SETTLE_CYCLES(16)) u_dut_small (
        .clk_sys(clk_sys), .reset(reset),
        .dl_download(dl_download), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .cpu_req(1'b0), .cpu_addr(15'd0), .cpu_ack(cpu_ack2), .cpu_data(cpu_data2),
        .gfx_req(1'b0), .gfx_addr(16'd0), .gfx_ack(gfx_ack2), .gfx_data(gfx_data2),
        .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_din(mem_din2), .mem_dout(8'h00),
        .game_reset(game_reset2), .dl_overflow(dl_overflow2)
    );

    always @(posedge clk_sys) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    always @(negedge clk_sys) begin
        if (cpu_ack) cpu_acks++;
        if (gfx_ack) gfx_acks++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_sys);
    endtask

    task automatic dl_byte(input logic [16:0] a, input logic [7:0] d);
        step(); dl_wr = 1'b1; dl_addr = a; dl_data = d;
        step(); dl_wr = 1'b0;
        step(); sample();
        check("dl_we", 32'(mem_we), 32'h1);
        check("dl_addr", 32'(mem_addr), 32'(a));
        check("dl_din", 32'(mem_din), 32'(d));
        step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; dl_download = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        cpu_req = 1'b0; cpu_addr = '0; gfx_req = 1'b0; gfx_addr = '0;

        // Reset values
        step(); step(); sample();
        check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        check("rst_gfx_ack", 32'(gfx_ack), 32'h0);
        check("rst_cpu_data", 32'(cpu_data), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_game_reset", 32'(game_reset), 32'h1);
        check("rst_ovf", 32'(dl_overflow), 32'h0);

        // Settle after reset release
        step(); reset = 1'b0;
        repeat (15) step();
        sample(); check("settle_rst_15", 32'(game_reset), 32'h1);
        step(); sample(); check("settle_rst_16", 32'(game_reset), 32'h0);

        // Preload ROM through the download path
        step(); dl_download = 1'b1;
        dl_byte(17'h01234, 8'h5A);
        dl_byte(17'h00100, 8'h77);
        dl_byte(17'h10ABC, 8'hC3);
        dl_byte(17'h00200, 8'h3C);
        dl_download = 1'b0;

        // Single CPU read, latency 3
        step(); cpu_req = 1'b1; cpu_addr = 15'h1234;
        sample(); check("cpu_idle_addr", 32'(mem_addr), 32'h0);
        step(); sample();
        check("cpu_rd_addr", 32'(mem_addr), 32'h01234);
        check("cpu_rd_we", 32'(mem_we), 32'h0);
        check("cpu_ack_n1", 32'(cpu_ack), 32'h0);
        step(); sample(); check("cpu_ack_n2", 32'(cpu_ack), 32'h0);
        step(); sample();
        check("cpu_ack_n3", 32'(cpu_ack), 32'h1);
        check("cpu_data_n3", 32'(cpu_data), 32'h5A);
        cpu_req = 1'b0;
        step(); sample();
        check("cpu_ack_n4", 32'(cpu_ack), 32'h0);
        check("cpu_data_hold", 32'(cpu_data), 32'h5A);

        // Round robin from reset pointer: CPU first, then alternate every 4 clocks
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        step(); cpu_req = 1'b1; cpu_addr = 15'h0100; gfx_req = 1'b1; gfx_addr = 16'h0ABC;
        step(); sample(); check("rr_q1_addr", 32'(mem_addr), 32'h00100);
        step(); step(); sample();
        check("rr_q3_cpu_ack", 32'(cpu_ack), 32'h1);
        check("rr_q3_cpu_data", 32'(cpu_data), 32'h77);
        check("rr_q3_gfx_ack", 32'(gfx_ack), 32'h0);
        step(); sample();
        check("rr_q4_cpu_ack", 32'(cpu_ack), 32'h0);
        check("rr_q4_idle_addr", 32'(mem_addr), 32'h0);
        step(); sample(); check("rr_q5_gfx_addr", 32'(mem_addr), 32'h10ABC);
        step(); step(); sample();
        check("rr_q7_gfx_ack", 32'(gfx_ack), 32'h1);
        check("rr_q7_gfx_data", 32'(gfx_data), 32'hC3);
        check("rr_q7_cpu_ack", 32'(cpu_ack), 32'h0);
        repeat (4) step();
        sample(); check("rr_q11_cpu_ack", 32'(cpu_ack), 32'h1);
        repeat (4) step();
        sample(); check("rr_q15_gfx_ack", 32'(gfx_ack), 32'h1);
        cpu_req = 1'b0; gfx_req = 1'b0;

        // Download with gfx_req pending throughout
        step(); dl_download = 1'b1; gfx_req = 1'b1; gfx_addr = 16'h0ABC;
        acks_before = gfx_acks;
        sample(); check("dl_game_reset", 32'(game_reset), 32'h1);
        for (int i = 0; i < 4; i++) dl_byte(17'(i), 8'(8'hA0 + i));
        check("dl_no_gfx_ack", 32'(gfx_acks), 32'(acks_before));
        dl_download = 1'b0;
        step(); step(); step(); sample();
        check("dl_end_gfx_ack", 32'(gfx_ack), 32'h1);
        check("dl_end_gfx_data", 32'(gfx_data), 32'hC3);
        gfx_req = 1'b0;
        repeat (12) step();
        sample(); check("dl_settle_15", 32'(game_reset), 32'h1);
        step(); sample(); check("dl_settle_16", 32'(game_reset), 32'h0);

        // dl_wr one clock after a CPU grant
        step(); cpu_req = 1'b1; cpu_addr = 15'h0200;
        step(); dl_wr = 1'b1; dl_addr = 17'h00010; dl_data = 8'hEE;
        step(); dl_wr = 1'b0;
        step(); sample();
        check("mix_cpu_ack", 32'(cpu_ack), 32'h1);
        check("mix_cpu_data", 32'(cpu_data), 32'h3C);
        check("mix_no_we", 32'(mem_we), 32'h0);
        check("mix_game_reset", 32'(game_reset), 32'h1);
        cpu_req = 1'b0;
        step(); sample();
        check("mix_we", 32'(mem_we), 32'h1);
        check("mix_addr", 32'(mem_addr), 32'h00010);
        check("mix_din", 32'(mem_din), 32'hEE);
        check("mix_model", 32'(mem[17'h00200]), 32'h3C);

        // Overflow on the 64 KiB instance
        repeat (20) step();
        dl_download = 1'b1;
        step(); dl_wr = 1'b1; dl_addr = 17'h10000; dl_data = 8'h55;
        step(); dl_wr = 1'b0;
        step(); sample();
        check("ovf_small_we", 32'(mem_we2), 32'h0);
        check("ovf_small_addr", 32'(mem_addr2), 32'h0);
        check("ovf_big_we", 32'(mem_we), 32'h1);
        check("ovf_big_addr", 32'(mem_addr), 32'h10000);
        step(); sample();
        check("ovf_small_flag", 32'(dl_overflow2), 32'h1);
        check("ovf_big_flag", 32'(dl_overflow), 32'h0);
        step(); step(); dl_download = 1'b0;
        sample(); check("ovf_sticky_fall", 32'(dl_overflow2), 32'h1);
        repeat (4) step();
        sample(); check("resettle_mid", 32'(game_reset), 32'h1);
        step(); dl_download = 1'b1;
        sample(); check("ovf_before_rise", 32'(dl_overflow2), 32'h1);
        step(); dl_download = 1'b0;
        sample(); check("ovf_clear_rise", 32'(dl_overflow2), 32'h0);
        repeat (15) step();
        sample(); check("resettle_15", 32'(game_reset), 32'h1);
        step(); sample(); check("resettle_16", 32'(game_reset), 32'h0);

        // Reset in RD_DATA aborts the read
        step(); cpu_req = 1'b1; cpu_addr = 15'h1234;
        step(); step(); sample();
        acks_before = cpu_acks;
        check("abort_pre_data", 32'(cpu_data), 32'h3C);
        reset = 1'b1;
        #1;
        check("abort_cpu_ack", 32'(cpu_ack), 32'h0);
        check("abort_cpu_data", 32'(cpu_data), 32'h0);
        check("abort_gfx_data", 32'(gfx_data), 32'h0);
        check("abort_mem_addr", 32'(mem_addr), 32'h0);
        check("abort_mem_we", 32'(mem_we), 32'h0);
        check("abort_game_reset", 32'(game_reset), 32'h1);
        step(); sample(); check("abort_no_ack", 32'(cpu_ack), 32'h0);
        step(); reset = 1'b0; cpu_req = 1'b0;
        step(); step();
        check("abort_ack_count", 32'(cpu_acks), 32'(acks_before));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
